// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage MDU operand/result bundle
interface e_mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO, MDUOut
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle mult/div unit with private HI/LO registers
// Result is computed at the start edge and parked in PHI/PLO until the count expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic [CW-1:0] count_q, count_d;
    logic          dz_q, dz_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, divisor, q_mag, r_mag, quot, rem;
    logic        is_sdiv, busy, start_ok;

    assign busy     = (count_q != '0);
    assign start_ok = bus.Start && !busy &&
                      (bus.MDUOp == OP_MULT || bus.MDUOp == OP_MULTU ||
                       bus.MDUOp == OP_DIV  || bus.MDUOp == OP_DIVU);

    // 64x64 multiplies of extended operands keep the low 64 bits exact for both signednesses.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide goes through magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        is_sdiv = (bus.MDUOp == OP_DIV);
        abs_a   = (is_sdiv && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
        abs_b   = (is_sdiv && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag   = abs_a / divisor;
        r_mag   = abs_a % divisor;
        quot    = (is_sdiv && (bus.A[31] ^ bus.B[31])) ? (32'd0 - q_mag) : q_mag;
        rem     = (is_sdiv && bus.A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        count_d = count_q;
        dz_d    = dz_q;
        if (busy) begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1) && !dz_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end else if (start_ok) begin
            case (bus.MDUOp)
                OP_MULT: begin
                    phi_d   = prod_s[63:32];
                    plo_d   = prod_s[31:0];
                    count_d = CW'(MULT_CYCLES);
                    dz_d    = 1'b0;
                end
                OP_MULTU: begin
                    phi_d   = prod_u[63:32];
                    plo_d   = prod_u[31:0];
                    count_d = CW'(MULT_CYCLES);
                    dz_d    = 1'b0;
                end
                default: begin
                    phi_d   = rem;
                    plo_d   = quot;
                    count_d = CW'(DIV_CYCLES);
                    dz_d    = (bus.B == 32'd0);
                end
            endcase
        end else if (!bus.Start) begin
            if (bus.MDUOp == OP_MTHI) hi_d = bus.A;
            if (bus.MDUOp == OP_MTLO) lo_d = bus.A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            count_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            count_q <= count_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.Busy   = busy;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.MDUOut = (bus.MDUOp == OP_MFHI) ? hi_q :
                        (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu
module tb_e_mdu;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    e_mdu_if bus ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All drive tasks begin and end on a falling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = st;
        @(posedge clk);
        @(negedge clk);
        bus.MDUOp = 4'd0;
        bus.Start = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %h want 0", bus.Busy); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.LO); end
    endtask

    task automatic test_mthi_mfhi;
        issue(4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
        bus.MDUOp = 4'd5;
        #1;
        n_cmp++; if (bus.MDUOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mfhi got %h want deadbeef", bus.MDUOut); end
        issue(4'd8, 32'h0BADF00D, 32'd0, 1'b0);
        bus.MDUOp = 4'd6;
        #1;
        n_cmp++; if (bus.MDUOut !== 32'h0BADF00D) begin n_bad++; $display("FAIL mflo got %h want 0badf00d", bus.MDUOut); end
        bus.MDUOp = 4'd0;
    endtask

    task automatic test_none;
        bus.MDUOp = 4'd0;
        #1;
        n_cmp++; if (bus.MDUOut !== 32'd0) begin n_bad++; $display("FAIL none_out got %h want 0", bus.MDUOut); end
        bus.MDUOp = 4'd7;
        bus.A     = 32'h5555;
        bus.Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.MDUOp = 4'd0;
        bus.Start = 1'b0;
        n_cmp++; if (bus.HI !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mthi_with_start got %h want deadbeef", bus.HI); end
    endtask

    task automatic test_mult;
        int n;
        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        bus.MDUOp = 4'd5;
        #1;
        n_cmp++; if (bus.MDUOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mfhi_busy got %h want deadbeef", bus.MDUOut); end
        bus.MDUOp = 4'd0;
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
        n_cmp++; if (bus.HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", bus.HI); end
        n_cmp++; if (bus.LO !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo got %h want fffffffa", bus.LO); end
    endtask

    task automatic test_div(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b, 1'b1);
        wait_idle(n);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want 10", name, n); end
        n_cmp++; if (bus.HI !== exp_hi) begin n_bad++; $display("FAIL %s_hi got %h want %h", name, bus.HI, exp_hi); end
        n_cmp++; if (bus.LO !== exp_lo) begin n_bad++; $display("FAIL %s_lo got %h want %h", name, bus.LO, exp_lo); end
    endtask

    task automatic test_div_zero;
        issue(4'd7, 32'h1234, 32'd0, 1'b0);
        issue(4'd8, 32'h5678, 32'd0, 1'b0);
        test_div("divzero", 4'd3, 32'd99, 32'd0, 32'h1234, 32'h5678);
    endtask

    task automatic test_illegal_busy;
        int n;
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        issue(4'd8, 32'hAAAA, 32'd0, 1'b0);
        issue(4'd2, 32'd5, 32'd5, 1'b1);
        wait_idle(n);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL illegal_busy_left got %0d want 3", n); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL illegal_hi got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd12) begin n_bad++; $display("FAIL illegal_lo got %h want c", bus.LO); end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(4'd2, 32'd6, 32'd7, 1'b1);
        wait_idle(n);
        issue(4'd4, 32'd100, 32'd7, 1'b1);
        n_cmp++; if (bus.LO !== 32'd42) begin n_bad++; $display("FAIL b2b_first_lo got %h want 2a", bus.LO); end
        wait_idle(n);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL b2b_busy_cycles got %0d want 10", n); end
        n_cmp++; if ({bus.HI, bus.LO} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL b2b_divu got %h_%h want 2_e", bus.HI, bus.LO); end
    endtask

    task automatic test_reset_midrun;
        int n;
        issue(4'd7, 32'h77, 32'd0, 1'b0);
        issue(4'd3, 32'd50, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %h want 0", bus.Busy); end
        n_cmp++; if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin n_bad++; $display("FAIL midrst_hilo got %h_%h want 0_0", bus.HI, bus.LO); end
        @(negedge clk);
        reset = 1'b1;
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
        n_cmp++; if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin n_bad++; $display("FAIL multu got %h_%h want fffffffe_00000001", bus.HI, bus.LO); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.MDUOp = 4'd0;
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b1;
        @(negedge clk);
        test_reset;
        test_mthi_mfhi;
        test_none;
        test_mult;
        test_div("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_div("divu", 4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        test_div("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        test_div_zero;
        test_illegal_busy;
        test_back_to_back;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage pipelined MIPS CPU. It sits beside the E-stage ALU and takes the same forwarded A/B operands. It runs multi-cycle mult/multu/div/divu operations into private HI/LO registers and serves mfhi/mflo/mthi/mtlo. Its Busy output drives the hazard unit, which stalls MDU-class instructions in D; MDUOut is muxed with the ALU result into the E/M pipeline register.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu
- DIV_CYCLES, 10, Busy duration for div/divu

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately while low
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- MDUOp  input  4  operation select: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
- Start  input  1  one-cycle pulse accompanying MDUOp 1–4
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- MDUOut  output  32  read data for mfhi/mflo

## Operation
- State: HI, LO, a count register, and pending result registers PHI and PLO. Busy = (count != 0).
- Reset (reset low, asynchronous): HI = 0, LO = 0, count = 0, PHI/PLO = 0, so Busy = 0.
- Start with MDUOp 1–4 at an edge while Busy = 0:
  - Compute the result from A/B sampled at that edge and latch it into PHI/PLO.
  - Load count with MULT_CYCLES or DIV_CYCLES.
- MULT: signed 32×32 → 64-bit product; PHI = product[63:32], PLO = product[31:0].
- MULTU: the same, unsigned.
- DIV: signed. PLO = quotient truncated toward zero; PHI = remainder, which takes the dividend's sign.
- DIVU: unsigned quotient into PLO, remainder into PHI.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives PLO = 0x80000000, PHI = 0.
- Divide by zero (B = 0): the operation still runs for the full DIV_CYCLES, but HI and LO keep their prior values at completion.
- Count behaviour at each edge while count != 0:
  - count decrements by one.
  - On the edge where count goes 1 → 0, HI <= PHI and LO <= PLO (except divide by zero).
- MTHI: HI <= A at the edge, only when Busy = 0 and Start = 0.
- MTLO: LO <= A at the edge, under the same conditions.
- MDUOut is combinational: MFHI → HI, MFLO → LO, any other MDUOp → 0.
- Start while Busy = 1 is a hazard-unit violation. It is ignored: count, PHI, PLO, HI and LO are unchanged.
- Start with MDUOp outside 1–4 is ignored.
- MTHI/MTLO while Busy = 1 is ignored.
- MDUOp 0 or 9–15: no state change.

## Timing
- Start sampled at edge t:
  - Busy is high in cycles t+1 … t+MULT_CYCLES for mult, t+1 … t+DIV_CYCLES for div.
  - New HI/LO are visible from the first cycle Busy is low: t+6 for mult, t+11 for div.
- The hazard unit stalls D when (Start || Busy) and the D instruction is MDU-class. The unit itself never blocks.
- Back-to-back Start is legal on the first cycle Busy = 0 after completion.
- MTHI/MTLO take effect at the sampling edge; MFHI/MFLO read in the following cycle returns the new value.
- MFHI/MFLO while Busy = 1 returns the old HI/LO. This cannot occur in a correctly stalled pipeline.
- Reset asserted mid-operation: Busy drops to 0 immediately (asynchronously), HI/LO = 0, and the pending result is discarded.
- Reset deasserted: the first Start is accepted at the next edge.

## Test plan
- Reset mid-run:
  - Reset low during cycle t+4 of a div → Busy = 0, HI = LO = 0 without waiting for an edge.
  - After release, Start MULTU with A = B = 0xFFFFFFFF → at t+6, HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed MULT with A = 0xFFFFFFFE (−2), B = 3:
  - Busy high for exactly 5 cycles.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFFA at t+6.
- DIV with A = −7, B = 2:
  - Busy high for 10 cycles.
  - LO = 0xFFFFFFFD, PHI path gives HI = 0xFFFFFFFF.
- DIVU with A = 7, B = 2 → LO = 3, HI = 1.
- DIV with A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide by zero: HI = 0x1234, LO = 0x5678 preset via MTHI/MTLO, then DIV with B = 0 → Busy high for 10 cycles, HI/LO unchanged afterwards.
- Illegal writes during Busy:
  - Start MULT, then MTLO A = 0xAAAA during Busy → ignored.
  - A second Start during Busy → ignored; the first result lands at t+6.
- MTHI A = 0xDEADBEEF, then MFHI next cycle → MDUOut = 0xDEADBEEF.
- MDUOp = NONE → MDUOut = 0.
